// File: rtl/intersection_scheduler.sv
// Two-approach intersection scheduler: sequences NS/EW lights through
// green -> yellow -> all-red, with min/max green and latched requests.
// NS is the default approach and holds green while nobody else asks.
module intersection_scheduler #(
  parameter int GREEN_MIN    = 4,
  parameter int GREEN_MAX    = 10,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_ns,
  input  logic       car_ew,
  output logic [1:0] light_ns,
  output logic [1:0] light_ew,
  output logic       allow_ns,
  output logic       allow_ew,
  output logic       pend_ns,
  output logic       pend_ew,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR_TO_NS  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    AR_TO_EW  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  localparam logic [1:0] LT_RED = 2'd0;
  localparam logic [1:0] LT_YEL = 2'd1;
  localparam logic [1:0] LT_GRN = 2'd3;

  // Terminal counts; the phase counter starts at 0 on entry, so a phase of
  // N cycles ends when cnt reaches N-1.
  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED_TIME - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pend_ns_n, pend_ew_n;
  logic             req_ns, req_ew;
  logic             ns_exit, ew_exit;
  logic             is_green;

  // Opposing demand includes the live input so a fresh arrival counts
  // on the same edge it is first seen.
  assign req_ns = pend_ns | car_ns;
  assign req_ew = pend_ew | car_ew;

  // Green may yield once minimum green is served and the own side has
  // either gone quiet or used up its maximum.
  assign ns_exit = req_ew && (cnt >= GMIN_M1) && (!car_ns || (cnt == GMAX_M1));
  assign ew_exit = req_ns && (cnt >= GMIN_M1) && (!car_ew || (cnt == GMAX_M1));

  assign is_green = (state == NS_GREEN) || (state == EW_GREEN);

  // Next-state, counter and pending-flag logic.
  always_comb begin
    state_n = state;
    case (state)
      AR_TO_NS:  if (cnt == AR_M1)  state_n = NS_GREEN;
      NS_GREEN:  if (ns_exit)       state_n = NS_YELLOW;
      NS_YELLOW: if (cnt == YEL_M1) state_n = AR_TO_EW;
      AR_TO_EW:  if (cnt == AR_M1)  state_n = EW_GREEN;
      EW_GREEN:  if (ew_exit)       state_n = EW_YELLOW;
      EW_YELLOW: if (cnt == YEL_M1) state_n = AR_TO_NS;
      default:                      state_n = AR_TO_NS;
    endcase

    // Greens saturate so the max-green compare stays valid while held;
    // the other phases always leave at their terminal count.
    if (state_n != state)
      cnt_n = '0;
    else if (is_green && (cnt == GMAX_M1))
      cnt_n = cnt;
    else
      cnt_n = cnt + 1'b1;

    // Entering the own green consumes the request, overriding a new set.
    if ((state_n == NS_GREEN) && (state != NS_GREEN))
      pend_ns_n = 1'b0;
    else
      pend_ns_n = pend_ns | (car_ns && (state != NS_GREEN));

    if ((state_n == EW_GREEN) && (state != EW_GREEN))
      pend_ew_n = 1'b0;
    else
      pend_ew_n = pend_ew | (car_ew && (state != EW_GREEN));
  end

  // State, counter and request registers with synchronous reset to all-red.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= AR_TO_NS;
      cnt     <= '0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend_ns <= pend_ns_n;
      pend_ew <= pend_ew_n;
    end
  end

  // Moore light decode from the registered state; only one approach can
  // ever decode to non-red because each state names a single approach.
  always_comb begin
    light_ns = LT_RED;
    light_ew = LT_RED;
    case (state)
      NS_GREEN:  light_ns = LT_GRN;
      NS_YELLOW: light_ns = LT_YEL;
      EW_GREEN:  light_ew = LT_GRN;
      EW_YELLOW: light_ew = LT_YEL;
      default: ;
    endcase
  end

  assign allow_ns = (state == NS_GREEN);
  assign allow_ew = (state == EW_GREEN);
  assign phase    = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed and random bench for intersection_scheduler (default parameters).
module tb_intersection_scheduler;

  logic       clk;
  logic       rst_n;
  logic       car_ns, car_ew;
  logic [1:0] light_ns, light_ew;
  logic       allow_ns, allow_ew;
  logic       pend_ns, pend_ew;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int WAIT_MAX = 10 + 2 * (2 + 1) + 1;

  intersection_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .car_ns   (car_ns),
    .car_ew   (car_ew),
    .light_ns (light_ns),
    .light_ew (light_ew),
    .allow_ns (allow_ns),
    .allow_ew (allow_ew),
    .pend_ns  (pend_ns),
    .pend_ew  (pend_ew),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge then release; returns just after edge E (NS green entry).
  task automatic reset_to_ns();
    rst_n  = 1'b0;
    car_ns = 1'b0;
    car_ew = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int wait_ns, wait_ew;
  logic [2:0] prev_ph;
  logic       legal;

  initial begin
    rst_n  = 1'b0;
    car_ns = 1'b0;
    car_ew = 1'b0;

    // 1: reset held 3 cycles, then release with no cars.
    repeat (3) tick();
    chk("rst_phase", phase, 0);
    chk("rst_lns", light_ns, 0);
    chk("rst_lew", light_ew, 0);
    chk("rst_allow", {allow_ns, allow_ew}, 0);
    chk("rst_pend", {pend_ns, pend_ew}, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_phase", phase, 1);
    chk("rel_lns", light_ns, 3);
    chk("rel_allow_ns", allow_ns, 1);
    for (int i = 0; i < 55; i++) begin
      tick();
      chk("idle_lew", light_ew, 0);
      chk("idle_lns", light_ns, 3);
    end

    // 2: minimum green with EW waiting from entry.
    reset_to_ns();
    car_ew = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 3) chk("min_green_hold", light_ns, 3);
      if (k == 4) begin chk("min_yel", light_ns, 1); chk("min_yel_ph", phase, 2); end
      if (k == 5) chk("min_yel2", light_ns, 1);
      if (k == 6) begin chk("min_ar_ph", phase, 3); chk("min_ar_l", {light_ns, light_ew}, 0); end
      if (k == 7) begin
        chk("min_ew_grn", light_ew, 3);
        chk("min_pend_clr", pend_ew, 0);
        chk("min_allow_ew", allow_ew, 1);
      end
    end
    car_ew = 1'b0;

    // 3: maximum green, NS requesting continuously, EW pulsed once.
    reset_to_ns();
    car_ns = 1'b1;
    car_ew = 1'b1;
    tick();
    car_ew = 1'b0;
    chk("max_pend_set", pend_ew, 1);
    for (int k = 2; k <= 13; k++) begin
      tick();
      if (k <= 9)  chk("max_green_hold", light_ns, 3);
      if (k == 4)  chk("max_pend_hold", pend_ew, 1);
      if (k == 10) chk("max_yel", light_ns, 1);
      if (k == 12) chk("max_ar", phase, 3);
      if (k == 13) chk("max_ew_grn", light_ew, 3);
    end

    // 4: early release when NS drops after minimum green.
    reset_to_ns();
    car_ns = 1'b1;
    car_ew = 1'b1;
    tick();
    car_ew = 1'b0;
    repeat (5) tick();
    chk("early_e6_grn", light_ns, 3);
    car_ns = 1'b0;
    tick();
    chk("early_yel", light_ns, 1);

    // 5: reset mid-yellow, with an NS request latched beforehand.
    car_ns = 1'b1;
    tick();
    chk("my_phase", phase, 2);
    chk("my_pend_ns", pend_ns, 1);
    rst_n = 1'b0;
    tick();
    chk("my_rst_l", {light_ns, light_ew}, 0);
    chk("my_rst_ph", phase, 0);
    chk("my_rst_pend", {pend_ns, pend_ew}, 0);
    rst_n  = 1'b1;
    car_ns = 1'b0;
    tick();
    chk("my_rel_ph", phase, 1);
    chk("my_rel_lns", light_ns, 3);

    // 6: random traffic with safety, legality and fairness checks.
    reset_to_ns();
    wait_ns = 0;
    wait_ew = 0;
    prev_ph = phase;
    for (int i = 0; i < 2000; i++) begin
      car_ns = ($urandom_range(0, 99) < 35);
      car_ew = ($urandom_range(0, 99) < 35);
      tick();
      chk("safe", ((light_ns != 0) && (light_ew != 0)) ? 1 : 0, 0);
      chk("allow_ns", allow_ns, (light_ns == 2'd3) ? 1 : 0);
      chk("allow_ew", allow_ew, (light_ew == 2'd3) ? 1 : 0);
      legal = (phase == prev_ph) || (phase == ((prev_ph == 3'd5) ? 3'd0 : prev_ph + 3'd1));
      chk("trans", legal, 1);
      chk("pend_ns_grn", (pend_ns && phase == 3'd1) ? 1 : 0, 0);
      chk("pend_ew_grn", (pend_ew && phase == 3'd4) ? 1 : 0, 0);
      wait_ns = pend_ns ? wait_ns + 1 : 0;
      wait_ew = pend_ew ? wait_ew + 1 : 0;
      chk("wait_ns", (wait_ns > WAIT_MAX) ? 1 : 0, 0);
      chk("wait_ew", (wait_ew > WAIT_MAX) ? 1 : 0, 0);
      prev_ph = phase;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Two-approach traffic-intersection scheduler that sequences the north-south (NS) and east-west (EW) light controllers. It guarantees that at most one approach is ever non-red. It arbitrates car-arrival requests with minimum and maximum green times, fixed yellow, and an all-red clearance interval. Its outputs drive each light controller's light-color and green-permission inputs, using the light encoding 0 = red, 1 = yellow, 3 = green.

## Interface
- GREEN_MIN, 4: minimum green cycles before the light may yield to a pending opposing request (≥1)
- GREEN_MAX, 10: maximum green cycles while the own approach keeps requesting (≥ GREEN_MIN)
- YELLOW_TIME, 2: yellow duration in cycles (≥1)
- ALL_RED_TIME, 1: all-red clearance duration in cycles (≥1)
- CNT_W, 8: phase counter width; must hold max(GREEN_MAX, YELLOW_TIME, ALL_RED_TIME) − 1
- clk  input  1  system clock, rising-edge
- rst_n  input  1  synchronous active-low reset
- car_ns  input  1  car present or arrived on the NS approach (level)
- car_ew  input  1  car present or arrived on the EW approach (level)
- light_ns  output  2  NS light color (0 red, 1 yellow, 3 green)
- light_ew  output  2  EW light color (same encoding)
- allow_ns  output  1  1 only while light_ns = green (street-light permission)
- allow_ew  output  1  1 only while light_ew = green
- pend_ns  output  1  latched NS request pending
- pend_ew  output  1  latched EW request pending
- phase  output  3  current FSM state code (debug)

## Operation
- FSM states and phase codes:
  - 0 AR_TO_NS: all red, NS next
  - 1 NS_GREEN
  - 2 NS_YELLOW
  - 3 AR_TO_EW: all red, EW next
  - 4 EW_GREEN
  - 5 EW_YELLOW
- Light decoding is Moore, from the registered state only:
  - NS_GREEN → light_ns = 3; NS_YELLOW → light_ns = 1; all other states → light_ns = 0.
  - EW is decoded the same way from EW_GREEN / EW_YELLOW.
- Safety invariant: light_ns and light_ew are never both non-zero.
- cnt resets to 0 on every state change and increments each cycle the state is held. In the green states it saturates at GREEN_MAX − 1.
- Pending flags:
  - pend_x sets on any edge where car_x = 1 and the state is not X_GREEN.
  - pend_x clears on the edge that enters X_GREEN; clear wins over set on that edge.
- Define other_req = pend_other | car_other, the live input OR'd in so there is no extra cycle of latency.
- X_GREEN → X_YELLOW when all of the following hold; otherwise stay green indefinitely:
  - other_req = 1
  - cnt ≥ GREEN_MIN − 1
  - car_x = 0, or cnt = GREEN_MAX − 1
- X_YELLOW → next all-red state when cnt = YELLOW_TIME − 1.
- AR_TO_NS → NS_GREEN and AR_TO_EW → EW_GREEN when cnt = ALL_RED_TIME − 1.
- No requests at all: NS stays green forever. NS is the default approach.
- Simultaneous car_ns and car_ew during all-red: ignored for the choice. The next green is fixed by the all-red state; the request on the red side is latched.

## Timing
- Reset: on any edge with rst_n = 0, the block loads:
  - state AR_TO_NS, cnt 0, pend_ns = pend_ew = 0
  - light_ns = light_ew = 0, allow_* = 0, phase = 0
- Reset applied mid-operation, including mid-yellow or mid-green, returns to all red on that same edge.
- After reset release, NS_GREEN is entered on the ALL_RED_TIME-th edge with rst_n = 1.
- Request-to-yellow latency: one edge after other_req first satisfies the green-exit condition.
- Green → yellow → all-red → opposite green takes exactly YELLOW_TIME + ALL_RED_TIME edges after leaving green.
- Minimum green is GREEN_MIN cycles. Green with a continuous own request is capped at GREEN_MAX cycles, and the cap applies only when the opposing side is pending.
- All outputs are registered or decoded from registers. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use default parameters.

1. **Reset release, no cars:** hold rst_n = 0 for 3 cycles, then release.
   - 1st edge with rst_n = 1: phase 0 → 1, light_ns = 3, allow_ns = 1.
   - NS stays green for 50+ cycles; light_ew = 0 throughout.
2. **Minimum green:** car_ew = 1 from NS_GREEN entry (edge E), car_ns = 0.
   - E+4: light_ns = 1.
   - E+6: all red, phase 3.
   - E+7: light_ew = 3, pend_ew = 0.
3. **Maximum green:** car_ns held at 1, car_ew pulsed for one cycle at E+1.
   - pend_ew holds 1.
   - light_ns goes yellow at E+10, not at E+4.
   - EW green at E+13.
4. **Early release:** as scenario 3, but car_ns drops at E+6.
   - light_ns = 1 at E+7.
5. **Reset mid-yellow:** assert rst_n = 0 while phase = 2.
   - Next edge: both lights 0, phase 0, pend flags 0.
   - After release, NS green is re-entered.
6. **Safety and fairness:** run 2000 cycles of random car_ns / car_ew.
   - A checker confirms both lights are never non-red together.
   - No pending request waits longer than GREEN_MAX + 2·(YELLOW_TIME + ALL_RED_TIME) + 1 cycles.
   - Every phase transition follows the FSM above.
